cd_spi_slave: RTL and testbench

SPI slave to CSR bridge that sits directly upstream of the CDBUS top level: it turns host SPI transactions into single-cycle CSR read/write strobes on the 5-bit address / 8-bit data CSR bus. All SPI pins are oversampled in the `clk` domain; no logic runs on `spi_sck`. It also drives the top level's `chip_select` so the RX RAM read port is only powered while a transaction is open.

---
 rtl/cd_spi_slave.sv | 213 +++++++++++++++++++++
 tb/tb_cd_spi_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cd_spi_slave.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : cd_spi_slave                                              |
// | Description : Oversampled SPI (mode 0) slave bridging host frames to    |
// |               single-cycle CSR read/write strobes. Optional macro       |
// |               CD_SPI_AUTOINC_EN enables header-controlled address       |
// |               auto-increment.                                           |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module cd_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_nss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       chip_select,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_nss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_flush;
  logic                   r_sck_prev;
  logic                   r_armed;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic       r_miso;
  logic       r_rd_pend;
  logic [4:0] r_csr_address;
  logic       r_csr_read;
  logic       r_csr_write;
  logic [7:0] r_csr_writedata;
`ifdef CD_SPI_AUTOINC_EN
  logic       r_autoinc;
`endif

  logic       w_sck;
  logic       w_nss;
  logic       w_mosi;
  logic       w_flushed;
  logic       w_rise;
  logic       w_fall;
  logic       w_active;
  logic       w_byte_done;
  logic [7:0] w_byte;

  // r_flush tracks when the synchronizers hold real pin samples after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_sync  <= '0;
      r_nss_sync  <= '1;
      r_mosi_sync <= '0;
      r_flush     <= '0;
      r_sck_prev  <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], spi_nss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_sck_prev  <= w_sck;
      if (w_flushed && w_nss) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_nss       = r_nss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_flushed   = r_flush[SYNC_STAGES-1];
  assign w_rise      = w_sck & ~r_sck_prev;
  assign w_fall      = ~w_sck & r_sck_prev;
  assign w_active    = (r_state != ST_IDLE) & ~w_nss;
  assign w_byte      = {r_rx, w_mosi};
  assign w_byte_done = w_active & w_rise & (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A frame only starts once nss has been seen high after reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_nss) begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_nss) begin
          w_state_nxt = ST_IDLE;
        end else if (w_byte_done) begin
          w_state_nxt = w_byte[7] ? ST_WR : ST_RD;
        end
      end
      default: begin
        if (w_nss) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt       <= 3'd0;
      r_rx            <= 7'd0;
      r_tx            <= 8'd0;
      r_miso          <= 1'b0;
      r_rd_pend       <= 1'b0;
      r_csr_address   <= 5'd0;
      r_csr_read      <= 1'b0;
      r_csr_write     <= 1'b0;
      r_csr_writedata <= 8'd0;
`ifdef CD_SPI_AUTOINC_EN
      r_autoinc       <= 1'b0;
`endif
    end else begin
      r_csr_read  <= 1'b0;
      r_csr_write <= 1'b0;
      r_rd_pend   <= r_csr_read;

      if (!w_active) begin
        r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= w_byte[6:0];
      end

      if (w_byte_done) begin
        case (r_state)
          ST_HDR: begin
            r_csr_address <= w_byte[4:0];
            r_csr_read    <= ~w_byte[7];
`ifdef CD_SPI_AUTOINC_EN
            r_autoinc     <= w_byte[6];
`endif
          end
          ST_WR: begin
            r_csr_write     <= 1'b1;
            r_csr_writedata <= w_byte;
          end
          ST_RD: begin
            // Speculative fetch for the next byte; it targets the next address.
            r_csr_read <= 1'b1;
`ifdef CD_SPI_AUTOINC_EN
            if (r_autoinc) begin
              r_csr_address <= r_csr_address + 5'd1;
            end
`endif
          end
          default: begin
          end
        endcase
      end

`ifdef CD_SPI_AUTOINC_EN
      if (r_csr_write && r_autoinc) begin
        r_csr_address <= r_csr_address + 5'd1;
      end
`endif

      if (r_rd_pend) begin
        r_tx <= csr_readdata;
      end else if (w_fall && (r_state == ST_RD)) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end

      if (r_state != ST_RD) begin
        r_miso <= 1'b0;
      end else if (w_fall) begin
        r_miso <= r_tx[7];
      end
    end
  end

  assign spi_miso      = r_miso;
  assign spi_miso_oe   = w_active;
  assign chip_select   = ~w_nss;
  assign csr_address   = r_csr_address;
  assign csr_read      = r_csr_read;
  assign csr_write     = r_csr_write;
  assign csr_writedata = r_csr_writedata;

endmodule
`default_nettype wire

// File: tb/tb_cd_spi_slave.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_cd_spi_slave                                           |
// | Description : Self-checking bench for cd_spi_slave with a frame-level   |
// |               reference model and an SPI host driver.                   |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module tb_cd_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 8;
`ifdef CD_SPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_sck;
  logic       spi_nss;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       chip_select;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata;
  logic       csr_write;
  logic [7:0] csr_writedata;

  always #5 clk = ~clk;

  cd_spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_sck      (spi_sck),
    .spi_nss      (spi_nss),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .chip_select  (chip_select),
    .csr_address  (csr_address),
    .csr_read     (csr_read),
    .csr_readdata (csr_readdata),
    .csr_write    (csr_write),
    .csr_writedata(csr_writedata)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] rd_vals [0:1023];
  int         rd_idx     = 0;
  bit         rd_pending = 1'b0;
  logic [4:0] wa_q [$];
  logic [7:0] wd_q [$];
  logic [4:0] ra_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // CSR side: readdata is presented only during the cycle after csr_read.
  always @(negedge clk) begin
    if (rd_pending) begin
      csr_readdata = rd_vals[rd_idx % 1024];
      rd_idx++;
    end else begin
      csr_readdata = 8'($urandom);
    end
    rd_pending = csr_read;
    if (csr_write) begin
      wa_q.push_back(csr_address);
      wd_q.push_back(csr_writedata);
    end
    if (csr_read) ra_q.push_back(csr_address);
    if (csr_read && csr_write) begin
      total++;
      bad++;
      $display("FAIL strobe_excl: read=%b write=%b, both high", csr_read, csr_write);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      wait_clk(HALF);
      r[7-i] = spi_miso;
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] hdr, input int n, input logic [31:0] data,
                           input int abort_bits, input int gap, input string tag);
    logic [7:0] r;
    logic [7:0] got [0:3];
    int         base;
    int         step;
    int         exp_a;
    base = rd_idx;
    if (!hdr[7]) begin
      for (int k = 0; k < n; k++) rd_vals[(base + k) % 1024] = data[31-8*k -: 8];
    end
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    spi_nss = 1'b0;
    wait_clk(HALF);
    xfer(hdr, 8, r);
    for (int k = 0; k < n; k++) xfer(data[31-8*k -: 8], 8, got[k]);
    if (abort_bits > 0) xfer(8'hA7, abort_bits, r);
    chk({tag, " oe_mid"}, 32'(spi_miso_oe), 32'd1);
    chk({tag, " cs_mid"}, 32'(chip_select), 32'd1);
    wait_clk(HALF);
    spi_nss = 1'b1;

    // Reference: start address from header, optional +1 per data byte, mod 32.
    step = (AUTOINC && hdr[6]) ? 1 : 0;
    if (hdr[7]) begin
      chk({tag, " wr_cnt"}, 32'(wa_q.size()), 32'(n));
      chk({tag, " rd_cnt"}, 32'(ra_q.size()), 32'd0);
      for (int k = 0; k < n && k < wa_q.size(); k++) begin
        exp_a = (int'(hdr[4:0]) + k * step) % 32;
        chk($sformatf("%s wr%0d addr_data", tag, k), {19'd0, wa_q[k], wd_q[k]},
            {19'd0, 5'(exp_a), data[31-8*k -: 8]});
      end
    end else begin
      chk({tag, " wr_cnt"}, 32'(wa_q.size()), 32'd0);
      chk({tag, " rd_cnt"}, 32'(ra_q.size()), 32'(n + 1));
      for (int k = 0; k <= n && k < ra_q.size(); k++) begin
        exp_a = (int'(hdr[4:0]) + k * step) % 32;
        chk($sformatf("%s rd%0d addr", tag, k), 32'(ra_q[k]), 32'(exp_a));
      end
      for (int k = 0; k < n; k++) begin
        chk($sformatf("%s miso%0d", tag, k), 32'(got[k]), 32'(data[31-8*k -: 8]));
      end
    end
    wait_clk(gap);
    chk({tag, " oe_end"}, 32'(spi_miso_oe), 32'd0);
    chk({tag, " cs_end"}, 32'(chip_select), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  hdr;
    int          n;
    logic [31:0] data;
    int          abort_bits;
    int          gap;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    logic [7:0] r;
    logic [7:0] h;
    int         n;

    vecs[0] = '{8'h83, 2, 32'h1122_0000, 0, 20};
    vecs[1] = '{8'h05, 2, 32'hA53C_0000, 0, 20};
    vecs[2] = '{8'hDF, 2, 32'h0102_0000, 0, 20};
    vecs[3] = '{8'h82, 0, 32'h0000_0000, 5, 20};
    vecs[4] = '{8'h82, 1, 32'h7700_0000, 0, 20};
    vecs[5] = '{8'h81, 1, 32'hAB00_0000, 0, SYNC + 1};
    vecs[6] = '{8'h04, 1, 32'h5A00_0000, 0, 20};

    for (int i = 0; i < 1024; i++) rd_vals[i] = 8'($urandom);

    reset_n  = 1'b0;
    spi_sck  = 1'b0;
    spi_nss  = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(4);
    chk("reset_outs", {14'd0, spi_miso, spi_miso_oe, chip_select, csr_read, csr_write,
                       csr_address, csr_writedata}, 32'd0);
    reset_n = 1'b1;
    wait_clk(6);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].hdr, vecs[i].n, vecs[i].data, vecs[i].abort_bits, vecs[i].gap,
                $sformatf("vec%0d", i));
    end

    // Reset in the middle of a read data byte, nss held low throughout.
    spi_nss = 1'b0;
    wait_clk(HALF);
    xfer(8'h05, 8, r);
    xfer(8'hC3, 3, r);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", {14'd0, spi_miso, spi_miso_oe, chip_select, csr_read, csr_write,
                         csr_address, csr_writedata}, 32'd0);
    wait_clk(3);
    reset_n = 1'b1;
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    xfer(8'hC3, 5, r);
    xfer(8'h81, 8, r);
    xfer(8'h55, 8, r);
    chk("rst_oe_wait", 32'(spi_miso_oe), 32'd0);
    wait_clk(HALF);
    spi_nss = 1'b1;
    wait_clk(10);
    chk("rst_no_wr", 32'(wa_q.size()), 32'd0);
    chk("rst_no_rd", 32'(ra_q.size()), 32'd0);
    run_frame(8'h83, 1, 32'h9900_0000, 0, 20, "post_rst");

    for (int i = 0; i < 12; i++) begin
      h = 8'($urandom);
      n = $urandom_range(0, 3);
      run_frame(h, n, $urandom, 0, $urandom_range(SYNC + 1, 12), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
